// File: rtl/prio_enco_seq.sv
// Sequential priority encoder: captures a request vector and emits each set
// bit's index, one per valid/ready beat, highest- or lowest-first.
module prio_enco_seq #(
  parameter int unsigned N         = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [N-1:0]         a_in,
  input  logic                 ready_in,
  output logic [$clog2(N)-1:0] y_op,
  output logic                 valid_op,
  output logic                 last_op,
  output logic                 busy_op,
  output logic                 zero_op,
  output logic [$clog2(N):0]   count_op
);

  localparam int unsigned W  = $clog2(N);
  localparam int unsigned CW = W + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t         state;
  logic [N-1:0]   pending;
  logic [N-1:0]   cleared;
  logic [W-1:0]   nxt_idx;
  logic [CW-1:0]  nxt_cnt;
  logic [W-1:0]   load_idx;
  logic [CW-1:0]  load_cnt;

  // Index of the highest (or lowest) set bit; 0 for an empty vector.
  function automatic logic [W-1:0] prio_idx(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (MSB_FIRST) begin
        if (v[i]) idx = W'(i);
      end else begin
        if (v[N-1-i]) idx = W'(N-1-i);
      end
    end
    return idx;
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < N; i++) cnt = cnt + CW'(v[i]);
    return cnt;
  endfunction

  // Look-ahead so the next index is ready on the same edge as a transfer.
  always_comb begin
    cleared  = pending & ~(N'(1) << y_op);
    nxt_idx  = prio_idx(cleared);
    nxt_cnt  = popcount(cleared);
    load_idx = prio_idx(a_in);
    load_cnt = popcount(a_in);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= '0;
      y_op     <= '0;
      valid_op <= 1'b0;
      last_op  <= 1'b0;
      busy_op  <= 1'b0;
      zero_op  <= 1'b0;
      count_op <= '0;
    end else begin
      zero_op <= 1'b0;
      if (!en) begin
        valid_op <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (load) begin
              pending  <= a_in;
              count_op <= load_cnt;
              if (a_in == '0) begin
                zero_op <= 1'b1;
              end else begin
                state    <= SCAN;
                busy_op  <= 1'b1;
                valid_op <= 1'b1;
                y_op     <= load_idx;
                last_op  <= (load_cnt == CW'(1));
              end
            end
          end
          SCAN: begin
            if (valid_op && ready_in) begin
              pending <= cleared;
              y_op    <= nxt_idx;
              last_op <= (nxt_cnt == CW'(1));
              if (last_op) begin
                state    <= IDLE;
                busy_op  <= 1'b0;
                valid_op <= 1'b0;
              end else begin
                valid_op <= 1'b1;
              end
            end else begin
              // Re-assert after an en pause; hold y_op/last_op while stalled.
              valid_op <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prio_enco_seq.sv
// Bench for prio_enco_seq: MSB-first and LSB-first instances share stimulus and
// are checked every cycle against a set-based model plus literal beat lists.
module tb_prio_enco_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] a_in = 8'h00;
  logic       ready_in = 1'b0;

  logic [2:0] y_m, y_l;
  logic       valid_m, valid_l, last_m, last_l, busy_m, busy_l, zero_m, zero_l;
  logic [3:0] count_m, count_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prio_enco_seq #(.N(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .en(en), .load(load), .a_in(a_in), .ready_in(ready_in),
    .y_op(y_m), .valid_op(valid_m), .last_op(last_m), .busy_op(busy_m),
    .zero_op(zero_m), .count_op(count_m)
  );

  prio_enco_seq #(.N(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .en(en), .load(load), .a_in(a_in), .ready_in(ready_in),
    .y_op(y_l), .valid_op(valid_l), .last_op(last_l), .busy_op(busy_l),
    .zero_op(zero_l), .count_op(count_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the pending set, whether a vector is held, and whether a beat is offered.
  function automatic int pick(input logic [7:0] p, input bit msb);
    int r;
    r = -1;
    for (int i = 0; i < 8; i++)
      if (p[i] && (msb || r < 0)) r = i;
    return (r < 0) ? 0 : r;
  endfunction

  function automatic int pop(input logic [7:0] p);
    int c;
    c = 0;
    for (int i = 0; i < 8; i++) c += int'(p[i]);
    return c;
  endfunction

  logic [7:0] mp [2];
  bit         mb [2];
  bit         mv [2];
  bit         mz [2];
  int         mc [2];

  always @(posedge clk or posedge rst) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        mp[m] = 8'h00; mb[m] = 1'b0; mv[m] = 1'b0; mz[m] = 1'b0; mc[m] = 0;
      end else begin
        mz[m] = 1'b0;
        if (!en) begin
          mv[m] = 1'b0;
        end else if (!mb[m]) begin
          if (load) begin
            mp[m] = a_in;
            mc[m] = pop(a_in);
            if (a_in == 8'h00) mz[m] = 1'b1;
            else begin mb[m] = 1'b1; mv[m] = 1'b1; end
          end
        end else begin
          if (mv[m] && ready_in) mp[m][pick(mp[m], (m == 0))] = 1'b0;
          if (mp[m] == 8'h00) begin mb[m] = 1'b0; mv[m] = 1'b0; end
          else mv[m] = 1'b1;
        end
      end
    end
  end

  task automatic cmp(input int m, input logic v, input logic b, input logic z,
                     input logic [3:0] c, input logic [2:0] y, input logic l);
    string s;
    s = (m == 0) ? "msb" : "lsb";
    chk({s, ".valid"}, v, mv[m]);
    chk({s, ".busy"}, b, mb[m]);
    chk({s, ".zero"}, z, mz[m]);
    chk({s, ".count"}, c, mc[m]);
    if (mv[m]) begin
      chk({s, ".y"}, y, pick(mp[m], (m == 0)));
      chk({s, ".last"}, l, (pop(mp[m]) == 1));
    end
  endtask

  // Per-cycle compare plus a snapshot of the offered beat for the transfer log.
  logic       sv_m, sv_l;
  logic [2:0] sy_m, sy_l;
  always @(negedge clk) begin
    sv_m = valid_m; sy_m = y_m; sv_l = valid_l; sy_l = y_l;
    if (!rst) begin
      cmp(0, valid_m, busy_m, zero_m, count_m, y_m, last_m);
      cmp(1, valid_l, busy_l, zero_l, count_l, y_l, last_l);
    end
  end

  int xm [64];
  int xl [64];
  int nm = 0;
  int nl = 0;
  int bm = 0;
  int bl = 0;
  always @(posedge clk) begin
    if (!rst && en && ready_in) begin
      if (sv_m) begin if (nm < 64) xm[nm] = int'(sy_m); nm++; end
      if (sv_l) begin if (nl < 64) xl[nl] = int'(sy_l); nl++; end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic mark();
    bm = nm;
    bl = nl;
  endtask

  task automatic check_seq(input string name, input int sel, input int len, input int ex[8]);
    int n;
    n = (sel == 0) ? (nm - bm) : (nl - bl);
    chk({name, ".beats"}, n, len);
    for (int i = 0; i < len && i < n; i++)
      chk($sformatf("%s[%0d]", name, i), (sel == 0) ? xm[bm + i] : xl[bl + i], ex[i]);
  endtask

  task automatic wait_xfers(input int n, input int budget);
    int k;
    k = 0;
    while ((nm - bm) < n && k < budget) begin cyc(); k++; end
    chk("wait_xfers", ((nm - bm) >= n), 1);
  endtask

  int ex_m[8];
  int ex_l[8];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset asserted away from any clock edge clears outputs at once.
    #2; rst = 1'b1; #1;
    chk("rst.valid", valid_m, 0); chk("rst.busy", busy_m, 0); chk("rst.zero", zero_m, 0);
    chk("rst.count", count_m, 0); chk("rst.y", y_m, 0); chk("rst.last", last_m, 0);
    chk("rst.valid_l", valid_l, 0);
    cyc(); cyc();
    rst = 1'b0; en = 1'b1;
    cyc();
    chk("idle.busy", busy_m, 0);

    // Three-bit vector, ready held high.
    mark(); a_in = 8'b1010_0100; load = 1'b1; ready_in = 1'b1;
    cyc(); load = 1'b0;
    chk("t2.valid", valid_m, 1); chk("t2.y_msb", y_m, 7); chk("t2.y_lsb", y_l, 2);
    chk("t2.last", last_m, 0); chk("t2.count", count_m, 3);
    repeat (5) cyc();
    ex_m = '{7, 5, 2, 0, 0, 0, 0, 0}; ex_l = '{2, 5, 7, 0, 0, 0, 0, 0};
    check_seq("t2_msb", 0, 3, ex_m); check_seq("t2_lsb", 1, 3, ex_l);
    chk("t2.busy_end", busy_m, 0); chk("t2.count_hold", count_m, 3);

    // Same vector, consumer stalls on the first beat.
    mark(); load = 1'b1; ready_in = 1'b0;
    cyc(); load = 1'b0;
    repeat (3) cyc();
    chk("t3.held_y", y_m, 7); chk("t3.held_valid", valid_m, 1); chk("t3.no_xfer", nm - bm, 0);
    ready_in = 1'b1;
    repeat (5) cyc();
    check_seq("t3_msb", 0, 3, ex_m); check_seq("t3_lsb", 1, 3, ex_l);

    // All-zero vector.
    a_in = 8'h00; load = 1'b1;
    cyc(); load = 1'b0;
    chk("t4.zero", zero_m, 1); chk("t4.zero_l", zero_l, 1);
    chk("t4.valid", valid_m, 0); chk("t4.count", count_m, 0);
    cyc();
    chk("t4.zero_pulse_end", zero_m, 0);

    // Full vector, load ignored during scan, en paused after beat 3.
    mark(); a_in = 8'hFF; load = 1'b1;
    cyc(); a_in = 8'h01;
    cyc(); load = 1'b0;
    wait_xfers(3, 20);
    en = 1'b0;
    cyc(); cyc();
    chk("t5.pause_valid", valid_m, 0); chk("t5.pause_valid_l", valid_l, 0);
    chk("t5.pause_y", y_m, 4); chk("t5.pause_y_l", y_l, 3); chk("t5.pause_busy", busy_m, 1);
    en = 1'b1;
    repeat (12) cyc();
    ex_m = '{7, 6, 5, 4, 3, 2, 1, 0}; ex_l = '{0, 1, 2, 3, 4, 5, 6, 7};
    check_seq("t5_msb", 0, 8, ex_m); check_seq("t5_lsb", 1, 8, ex_l);
    chk("t5.count", count_m, 8);

    // Reset in the middle of a scan.
    mark(); a_in = 8'b1111_0000; load = 1'b1;
    cyc(); load = 1'b0;
    wait_xfers(2, 10);
    rst = 1'b1; #1;
    chk("t6.valid", valid_m, 0); chk("t6.busy", busy_m, 0); chk("t6.y", y_m, 0);
    chk("t6.count", count_m, 0); chk("t6.valid_l", valid_l, 0);
    cyc(); rst = 1'b0;
    mark(); a_in = 8'b0000_0011; load = 1'b1;
    cyc(); load = 1'b0;
    chk("t6.last_first", last_m, 0);
    repeat (5) cyc();
    ex_m = '{1, 0, 0, 0, 0, 0, 0, 0}; ex_l = '{0, 1, 0, 0, 0, 0, 0, 0};
    check_seq("t6_msb", 0, 2, ex_m); check_seq("t6_lsb", 1, 2, ex_l);
    chk("t6.busy_end", busy_m, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
